paddle_ctrl: RTL and testbench

Per-frame paddle motion controller for the Pong core. Consumes the debounced, held button codes of both players and sequences each paddle's vertical position once per video frame. Uses a slow/fast hold-to-accelerate state machine and clamps to the playfield. Sits between the two button debouncers and the renderer/collision logic, which read `p1_y`/`p2_y`.

---
 rtl/pong_pkg.sv | 44 ++++
 rtl/paddle_axis.sv | 137 +++++++++++++
 rtl/paddle_ctrl.sv | 47 ++++
 tb/tb_paddle_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and geometry helpers for the Pong core: button direction
// encoding, paddle FSM states and playfield limit derivation.
package pong_pkg;

  localparam int SCREEN_H_DEF    = 480;
  localparam int PADDLE_H_DEF    = 64;
  localparam int Y_W_DEF         = 10;
  localparam int STEP_DEF        = 4;
  localparam int FAST_STEP_DEF   = 8;
  localparam int HOLD_FRAMES_DEF = 8;

  // Values mirror the raw button code so decoding is a straight compare.
  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_DOWN = 2'b01,
    DIR_UP   = 2'b10
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SLOW = 2'b01,
    ST_FAST = 2'b10
  } paddle_state_t;

  function automatic int y_max(input int screen_h, input int paddle_h);
    return screen_h - paddle_h;
  endfunction

  function automatic int y_center(input int screen_h, input int paddle_h);
    return y_max(screen_h, paddle_h) / 2;
  endfunction

  // Both buttons pressed cancels out, same as none pressed.
  function automatic dir_t decode_dir(input logic [1:0] btns);
    dir_t d;
    case (btns)
      2'b10:   d = DIR_UP;
      2'b01:   d = DIR_DOWN;
      default: d = DIR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/paddle_axis.sv
// One player's paddle: direction decode, slow/fast hold FSM, hold counter
// and playfield clamp. Position and fast flag are registered.
module paddle_axis
  import pong_pkg::*;
#(
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int PADDLE_H    = PADDLE_H_DEF,
  parameter int Y_W         = Y_W_DEF,
  parameter int STEP        = STEP_DEF,
  parameter int FAST_STEP   = FAST_STEP_DEF,
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           recenter,
  input  logic [1:0]     btns,
  output logic [Y_W-1:0] y,
  output logic           fast
);

  localparam int YMAX    = y_max(SCREEN_H, PADDLE_H);
  localparam int YCENTER = y_center(SCREEN_H, PADDLE_H);
  localparam int HW      = $clog2(HOLD_FRAMES + 1);
  localparam int ONE     = 1;

  localparam logic [Y_W:0]   YMAX_X    = YMAX[Y_W:0];
  localparam logic [Y_W-1:0] YCENTER_Y = YCENTER[Y_W-1:0];
  localparam logic [Y_W:0]   STEP_X    = STEP[Y_W:0];
  localparam logic [Y_W:0]   FAST_X    = FAST_STEP[Y_W:0];
  localparam logic [HW-1:0]  HOLD_MAX  = HOLD_FRAMES[HW-1:0];
  localparam logic [HW-1:0]  HOLD_ONE  = ONE[HW-1:0];
  // State entered after the first frame of a fresh run of one direction.
  localparam paddle_state_t  FIRST_ST  = (HOLD_FRAMES <= 1) ? ST_FAST : ST_SLOW;

  paddle_state_t  state_r, state_s;
  dir_t           last_dir_r, last_dir_s, dir_s, move_s;
  logic [HW-1:0]  hold_r, hold_s, hold_inc_s;
  logic [Y_W:0]   step_s, y_ext_s, diff_s, sum_s;
  logic [Y_W-1:0] y_r, y_s;
  logic           fast_r;

  assign dir_s      = decode_dir(btns);
  assign hold_inc_s = (hold_r >= HOLD_MAX) ? HOLD_MAX : hold_r + HOLD_ONE;

  // Next FSM state, hold count and requested move for this tick.
  always_comb begin
    state_s    = state_r;
    last_dir_s = last_dir_r;
    hold_s     = hold_r;
    move_s     = DIR_NONE;
    step_s     = STEP_X;
    if (tick) begin
      case (state_r)
        ST_IDLE: begin
          if (dir_s != DIR_NONE) begin
            move_s     = dir_s;
            hold_s     = HOLD_ONE;
            last_dir_s = dir_s;
            state_s    = FIRST_ST;
          end else begin
            hold_s = {HW{1'b0}};
          end
        end
        ST_SLOW: begin
          if (dir_s == DIR_NONE) begin
            state_s = ST_IDLE;
            hold_s  = {HW{1'b0}};
          end else if (dir_s != last_dir_r) begin
            move_s     = dir_s;
            hold_s     = HOLD_ONE;
            last_dir_s = dir_s;
            state_s    = FIRST_ST;
          end else begin
            move_s  = dir_s;
            hold_s  = hold_inc_s;
            state_s = (hold_inc_s >= HOLD_MAX) ? ST_FAST : ST_SLOW;
          end
        end
        ST_FAST: begin
          if (dir_s == DIR_NONE) begin
            state_s = ST_IDLE;
            hold_s  = {HW{1'b0}};
          end else if (dir_s == last_dir_r) begin
            move_s = dir_s;
            step_s = FAST_X;
          end else begin
            move_s     = dir_s;
            hold_s     = HOLD_ONE;
            last_dir_s = dir_s;
            state_s    = FIRST_ST;
          end
        end
        default: begin
          state_s    = ST_IDLE;
          hold_s     = {HW{1'b0}};
          last_dir_s = DIR_NONE;
        end
      endcase
    end else begin
      move_s = DIR_NONE;
    end
  end

  // Clamp the requested move to [0, YMAX]; the FSM advances regardless.
  always_comb begin
    y_ext_s = {1'b0, y_r};
    diff_s  = y_ext_s - step_s;
    sum_s   = y_ext_s + step_s;
    case (move_s)
      DIR_UP:   y_s = (y_ext_s < step_s) ? {Y_W{1'b0}} : diff_s[Y_W-1:0];
      DIR_DOWN: y_s = (sum_s > YMAX_X) ? YMAX_X[Y_W-1:0] : sum_s[Y_W-1:0];
      default:  y_s = y_r;
    endcase
  end

  // State registers; reset and recenter both restore the centred idle paddle.
  always_ff @(posedge clk) begin
    if (rst || recenter) begin
      state_r    <= ST_IDLE;
      last_dir_r <= DIR_NONE;
      hold_r     <= {HW{1'b0}};
      y_r        <= YCENTER_Y;
      fast_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      last_dir_r <= last_dir_s;
      hold_r     <= hold_s;
      y_r        <= y_s;
      fast_r     <= (state_s == ST_FAST);
    end
  end

  assign y    = y_r;
  assign fast = fast_r;

endmodule

// File: rtl/paddle_ctrl.sv
// Two-player paddle motion controller: gates frame ticks with enable and
// recenter, and drives one paddle_axis per player.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int PADDLE_H    = PADDLE_H_DEF,
  parameter int Y_W         = Y_W_DEF,
  parameter int STEP        = STEP_DEF,
  parameter int FAST_STEP   = FAST_STEP_DEF,
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_tick,
  input  logic           enable,
  input  logic           recenter,
  input  logic [1:0]     p1_btns,
  input  logic [1:0]     p2_btns,
  output logic [Y_W-1:0] p1_y,
  output logic [Y_W-1:0] p2_y,
  output logic           p1_fast,
  output logic           p2_fast
);

  logic tick_s;

  // Recenter outranks a tick arriving in the same cycle.
  assign tick_s = frame_tick & enable & ~recenter;

  paddle_axis #(
    .SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H), .Y_W(Y_W),
    .STEP(STEP), .FAST_STEP(FAST_STEP), .HOLD_FRAMES(HOLD_FRAMES)
  ) u_p1 (
    .clk(clk), .rst(rst), .tick(tick_s), .recenter(recenter),
    .btns(p1_btns), .y(p1_y), .fast(p1_fast)
  );

  paddle_axis #(
    .SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H), .Y_W(Y_W),
    .STEP(STEP), .FAST_STEP(FAST_STEP), .HOLD_FRAMES(HOLD_FRAMES)
  ) u_p2 (
    .clk(clk), .rst(rst), .tick(tick_s), .recenter(recenter),
    .btns(p2_btns), .y(p2_y), .fast(p2_fast)
  );

endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl: a run-length reference model predicts
// every cycle's outputs; a negedge monitor compares them against the DUT.
module tb_paddle_ctrl;

  localparam int YMAX = 416;
  localparam int YC   = 208;
  localparam int STP  = 4;
  localparam int FSTP = 8;
  localparam int HF   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b1;
  logic       recenter = 1'b0;
  logic [1:0] p1_btns = 2'b00;
  logic [1:0] p2_btns = 2'b00;
  logic [9:0] p1_y, p2_y;
  logic       p1_fast, p2_fast;

  paddle_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
    .recenter(recenter), .p1_btns(p1_btns), .p2_btns(p2_btns),
    .p1_y(p1_y), .p2_y(p2_y), .p1_fast(p1_fast), .p2_fast(p2_fast)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int y1;
    int y2;
    int f1;
    int f2;
  } exp_t;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  // Reference model: position, length of current same-direction run, last dir.
  int m_y[2];
  int m_run[2];
  int m_last[2];
  int m_fast[2];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dec(input logic [1:0] b);
    if (b == 2'b10) return -1;
    if (b == 2'b01) return 1;
    return 0;
  endfunction

  task automatic m_center();
    for (int p = 0; p < 2; p++) begin
      m_y[p] = YC; m_run[p] = 0; m_last[p] = 0; m_fast[p] = 0;
    end
  endtask

  task automatic m_advance(input int p, input logic [1:0] b);
    int d, step, ny;
    d = dec(b);
    step = STP;
    if (d == 0) begin
      m_run[p] = 0;
      m_fast[p] = 0;
    end else if (d == m_last[p] && m_run[p] > 0) begin
      step = (m_run[p] >= HF) ? FSTP : STP;
      m_run[p]++;
      m_fast[p] = (m_run[p] >= HF) ? 1 : 0;
    end else begin
      m_run[p] = 1;
      m_fast[p] = (HF <= 1) ? 1 : 0;
    end
    m_last[p] = d;
    ny = m_y[p] + d * step;
    if (ny < 0) ny = 0;
    if (ny > YMAX) ny = YMAX;
    m_y[p] = ny;
  endtask

  // Drive one cycle of inputs and push the outputs expected after the edge.
  task automatic drive(input bit ft, input bit en, input bit rc, input bit r,
                       input logic [1:0] b1, input logic [1:0] b2);
    exp_t e;
    @(posedge clk); #1;
    frame_tick = ft; enable = en; recenter = rc; rst = r;
    p1_btns = b1; p2_btns = b2;
    if (r || rc) m_center();
    else if (ft && en) begin
      m_advance(0, b1);
      m_advance(1, b2);
    end
    e.cyc = cyc_cnt + 1;
    e.y1 = m_y[0]; e.y2 = m_y[1]; e.f1 = m_fast[0]; e.f2 = m_fast[1];
    q.push_back(e);
  endtask

  // One frame: a tick cycle followed by a quiet cycle with buttons held.
  task automatic tick(input logic [1:0] b1, input logic [1:0] b2, input bit en);
    drive(1'b1, en, 1'b0, 1'b0, b1, b2);
    drive(1'b0, en, 1'b0, 1'b0, b1, b2);
  endtask

  // Monitor: pop every expectation due this cycle and compare.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc_cnt) cmp("sb_stale", e.cyc, cyc_cnt);
      else begin
        cmp("sb_p1_y", int'(p1_y), e.y1);
        cmp("sb_p2_y", int'(p2_y), e.y2);
        cmp("sb_p1_fast", int'(p1_fast), e.f1);
        cmp("sb_p2_fast", int'(p2_fast), e.f2);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, queue=%0d expected 0", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    m_center();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    cmp("reset_p1_y", int'(p1_y), 208);
    cmp("reset_p2_y", int'(p2_y), 208);

    // Player 1 holds up: slow for 8 frames, then fast.
    for (int i = 1; i <= 10; i++) begin
      tick(2'b10, 2'b00, 1'b1);
      if (i == 8) begin
        cmp("p1_tick8_y", int'(p1_y), 176);
        cmp("p1_tick8_fast", int'(p1_fast), 1);
      end
    end
    cmp("p1_tick10_y", int'(p1_y), 160);
    cmp("p2_idle_y", int'(p2_y), 208);

    // Player 2 runs into the top then the bottom limit.
    for (int i = 1; i <= 31; i++) begin
      tick(2'b00, 2'b10, 1'b1);
      if (i == 30) cmp("p2_top_t30", int'(p2_y), 0);
    end
    cmp("p2_top_t31_y", int'(p2_y), 0);
    cmp("p2_top_t31_fast", int'(p2_fast), 1);
    for (int i = 0; i < 60; i++) tick(2'b00, 2'b01, 1'b1);
    cmp("p2_bottom_y", int'(p2_y), 416);

    // Both buttons cancel; then 9 up frames and a single reversal.
    for (int i = 0; i < 5; i++) tick(2'b11, 2'b00, 1'b1);
    cmp("p1_both_y", int'(p1_y), 160);
    cmp("p1_both_fast", int'(p1_fast), 0);
    for (int i = 0; i < 9; i++) tick(2'b10, 2'b00, 1'b1);
    cmp("p1_up9_y", int'(p1_y), 120);
    tick(2'b01, 2'b00, 1'b1);
    cmp("p1_rev_y", int'(p1_y), 124);
    cmp("p1_rev_fast", int'(p1_fast), 0);

    // Enable low freezes position and hold progress.
    tick(2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) tick(2'b10, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) tick(2'b10, 2'b00, 1'b0);
    cmp("p1_frozen_y", int'(p1_y), 112);
    for (int i = 0; i < 4; i++) tick(2'b10, 2'b00, 1'b1);
    cmp("p1_resume4_y", int'(p1_y), 96);
    cmp("p1_resume4_fast", int'(p1_fast), 0);
    tick(2'b10, 2'b00, 1'b1);
    cmp("p1_resume5_fast", int'(p1_fast), 1);

    // Recenter from the limits in the same cycle as a tick.
    for (int i = 0; i < 60; i++) tick(2'b10, 2'b01, 1'b1);
    cmp("p1_at_top", int'(p1_y), 0);
    cmp("p2_at_bottom", int'(p2_y), 416);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b01);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01);
    cmp("rc_p1_y", int'(p1_y), 208);
    cmp("rc_p2_y", int'(p2_y), 208);
    cmp("rc_p1_fast", int'(p1_fast), 0);
    cmp("rc_p2_fast", int'(p2_fast), 0);

    // Reset in the middle of fast motion, with a tick in the same cycle.
    for (int i = 0; i < 10; i++) tick(2'b00, 2'b01, 1'b1);
    cmp("p2_fast_before_rst", int'(p2_fast), 1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b01);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01);
    cmp("rst_p2_y", int'(p2_y), 208);
    cmp("rst_p2_fast", int'(p2_fast), 0);

    // Randomized traffic, including multi-cycle ticks and button noise.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 99) < 33) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 90) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
            ($urandom_range(0, 199) < 1) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    cmp("sb_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
